mu0_seq_control: RTL
====================

# mu0_seq_control

Parametrised next-generation MU0 control unit: fetch/execute sequencer plus instruction decode, driving the existing MU0 datapath (PC, IR, Acc, X/Y muxes, ALU, memory port). Unlike the two-state zero-wait controller, it stalls on a memory ready handshake and halts with an error code on memory timeout. It also issues a one-cycle retire pulse per completed instruction and supports a configurable opcode field width. It sits between the datapath's IR/flag outputs and the datapath enables/selects.

## Interface
- F_W, 4, opcode field width (IR top bits); legal range 3..8
- MAX_WAIT, 15, max consecutive Mem_Rdy-low cycles tolerated per memory phase; 0 = no timeout
- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- F  input  F_W  opcode from IR
- N  input  1  Acc negative flag
- Z  input  1  Acc zero flag
- Mem_Rdy  input  1  memory completes current Rd/Wr this cycle
- fetch  output  1  state is FETCH
- PC_En, IR_En, Acc_En  output  1  register update enables
- X_sel  output  1  0 Acc, 1 PC
- Y_sel  output  1  0 Data In, 1 IR operand
- Addr_sel  output  1  0 PC, 1 IR operand
- M  output  2  ALU op: 0 Y, 1 X+Y, 2 X+1, 3 X-Y
- Rd, Wr  output  1  memory strobes
- Retire  output  1  one-cycle pulse, instruction completed
- Halted  output  1  state is HALT
- Err_code  output  2  0 none, 1 memory timeout, 2 illegal opcode

## Operation
- States: FETCH, EXEC, HALT. Reset → FETCH. HALT is absorbing until Reset.
- FETCH: Addr_sel=0, Rd=1, X_sel=1, M=2. On Mem_Rdy: PC_En=IR_En=1, → EXEC. Without Mem_Rdy: hold, all enables 0.
- EXEC by opcode (values zero-extended to F_W):
  - 0 LDA: Addr_sel=1, Rd=1, Y_sel=0, M=0, Acc_En=Mem_Rdy.
  - 1 STA: Addr_sel=1, Wr=1, X_sel=0.
  - 2 ADD / 3 SUB: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=1/3, Acc_En=Mem_Rdy.
  - 4 JMP: Y_sel=1, M=0, PC_En=1.
  - 5 JGE: as JMP, PC_En=~N.
  - 6 JNE: as JMP, PC_En=~Z.
  - 7 STP: → HALT, Err_code stays 0.
  - ≥8: illegal, see Configuration.
- Memory-phase states (FETCH, EXEC of 0–3) leave only on Mem_Rdy; non-memory EXEC ignores Mem_Rdy and always completes in one cycle.
- EXEC completion: Retire=1 and → FETCH (STP: Retire=1, → HALT).
- Unused strobes/enables are 0; unused selects are 0.
- Wait counter (width clog2(MAX_WAIT+1)) counts consecutive Mem_Rdy-low cycles in a memory phase; it clears on phase completion and on state change.
- Timeout: counter==MAX_WAIT and Mem_Rdy low → next edge HALT, Err_code=1. Mem_Rdy high in that same cycle completes normally (ready wins).
- HALT: all strobes, enables and Retire 0; Halted=1; Err_code sticky.

## Timing
- Reset values: state FETCH (fetch=1, Rd=1, X_sel=1, M=2, others 0), Err_code=0, counter=0, Retire=0, Halted=0. PC_En/IR_En/Acc_En are forced 0 while Reset is high.
- Zero-wait memory: 2 cycles per instruction; each wait cycle adds 1 to its phase.
- Decode outputs are combinational from state, F, N, Z and Mem_Rdy. State, counter and Err_code are registered.
- Reset asserted mid-stall or in HALT: immediate return to FETCH, Err_code cleared.

## Configuration
- MU0_ILLEGAL_TRAP_EN defined: opcode ≥8 in EXEC → HALT, Err_code=2, Retire=0.
- Undefined: opcode ≥8 executes as a NOP (no enables, no strobes), Retire=1, → FETCH.

## Structure
- Shared package mu0_pkg holds:
  - opcode constants;
  - state encoding type;
  - Err_code constants;
  - ALU M constants;
  - X/Y/Addr select constants.
- One sub-module, mu0_wait_timer, holds the wait counter and timeout compare (inputs: phase active, Mem_Rdy, phase change; output: timeout). Decode and FSM stay in the top.

## Test plan
- Program LDA 10; ADD 11; STA 12; STP with Mem_Rdy tied 1 → 2 cycles per instruction, 4 Retire pulses, Halted=1, Err_code=0.
- JGE with N=1 then N=0 → PC_En 0 then 1, and Mem_Rdy is ignored (held 0) in that EXEC.
- LDA with Mem_Rdy low for 3 cycles (MAX_WAIT=15) → EXEC lasts 4 cycles, Acc_En high only in the 4th.
- Mem_Rdy held low in FETCH, MAX_WAIT=4 → HALT after 5th low cycle, Err_code=1; variant with Mem_Rdy rising on the 5th cycle → normal IR load, no error.
- Opcode 9: with MU0_ILLEGAL_TRAP_EN → HALT, Err_code=2; without → NOP, Retire=1, back to FETCH.
- Reset asserted mid-stall and again in HALT → next cycle fetch=1, Err_code=0, no enables during Reset.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcodes, states, error codes,
// ALU functions and datapath select encodings.
package mu0_pkg;

  localparam int unsigned OP_W = 8;

  // Opcodes, zero-extended to the widest legal opcode field
  localparam logic [OP_W-1:0] OP_LDA = 8'd0;
  localparam logic [OP_W-1:0] OP_STA = 8'd1;
  localparam logic [OP_W-1:0] OP_ADD = 8'd2;
  localparam logic [OP_W-1:0] OP_SUB = 8'd3;
  localparam logic [OP_W-1:0] OP_JMP = 8'd4;
  localparam logic [OP_W-1:0] OP_JGE = 8'd5;
  localparam logic [OP_W-1:0] OP_JNE = 8'd6;
  localparam logic [OP_W-1:0] OP_STP = 8'd7;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;

  localparam logic [1:0] ALU_Y   = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_INC = 2'd2;
  localparam logic [1:0] ALU_SUB = 2'd3;

  localparam logic X_ACC   = 1'b0;
  localparam logic X_PC    = 1'b1;
  localparam logic Y_DIN   = 1'b0;
  localparam logic Y_IR    = 1'b1;
  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;

  // Opcodes 0..3 touch memory during EXEC
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op <= OP_SUB);
  endfunction

  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    return (op > OP_STP);
  endfunction

endpackage

// File: rtl/mu0_wait_timer.sv
// Counts consecutive not-ready cycles of a memory phase and flags a timeout
// once MAX_WAIT of them have elapsed (MAX_WAIT = 0 disables the timeout).
module mu0_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_phase_active,
  input  logic i_mem_rdy,
  input  logic i_phase_chg,
  output logic o_timeout
);

  localparam int unsigned CW    = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);
  localparam bit TO_EN = (MAX_WAIT != 0);

  logic [CW-1:0] r_cnt;
  logic          w_clear;

  assign w_clear = i_phase_chg | ~i_phase_active | i_mem_rdy;

  // Saturates at LIMIT; the FSM leaves the phase on the same edge anyway
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_timeout = TO_EN & i_phase_active & ~i_mem_rdy & (r_cnt == LIMIT);

endmodule

// File: rtl/mu0_seq_control.sv
// MU0 fetch/execute sequencer with memory-ready stalls, timeout halt and
// retire pulse. Optional build macro: MU0_ILLEGAL_TRAP_EN (trap opcodes >= 8).
module mu0_seq_control
  import mu0_pkg::*;
#(
  parameter int unsigned F_W      = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [F_W-1:0] F,
  input  logic           N,
  input  logic           Z,
  input  logic           Mem_Rdy,
  output logic           fetch,
  output logic           PC_En,
  output logic           IR_En,
  output logic           Acc_En,
  output logic           X_sel,
  output logic           Y_sel,
  output logic           Addr_sel,
  output logic [1:0]     M,
  output logic           Rd,
  output logic           Wr,
  output logic           Retire,
  output logic           Halted,
  output logic [1:0]     Err_code
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [1:0]      r_err;
  logic [1:0]      w_err_nxt;
  logic [OP_W-1:0] w_op;
  logic            w_mem_phase;
  logic            w_phase_chg;
  logic            w_timeout;
  logic            w_pc_en;
  logic            w_ir_en;
  logic            w_acc_en;

  assign w_op        = OP_W'(F);
  assign w_mem_phase = (r_state == ST_FETCH) ||
                       ((r_state == ST_EXEC) && is_mem_op(w_op));
  assign w_phase_chg = (w_state_nxt != r_state);

  mu0_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .i_clk         (Clk),
    .i_rst         (Reset),
    .i_phase_active(w_mem_phase),
    .i_mem_rdy     (Mem_Rdy),
    .i_phase_chg   (w_phase_chg),
    .o_timeout     (w_timeout)
  );

  // State and sticky error register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_FETCH;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; ready always wins over a same-cycle timeout
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_FETCH: begin
        if (Mem_Rdy) begin
          w_state_nxt = ST_EXEC;
        end else if (w_timeout) begin
          w_state_nxt = ST_HALT;
          w_err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (is_mem_op(w_op)) begin
          if (Mem_Rdy) begin
            w_state_nxt = ST_FETCH;
          end else if (w_timeout) begin
            w_state_nxt = ST_HALT;
            w_err_nxt   = ERR_TIMEOUT;
          end
        end else if (w_op == OP_STP) begin
          w_state_nxt = ST_HALT;
        end else if (is_illegal_op(w_op)) begin
`ifdef MU0_ILLEGAL_TRAP_EN
          w_state_nxt = ST_HALT;
          w_err_nxt   = ERR_ILLEGAL;
`else
          w_state_nxt = ST_FETCH;
`endif
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Decode outputs
  always_comb begin
    w_pc_en  = 1'b0;
    w_ir_en  = 1'b0;
    w_acc_en = 1'b0;
    X_sel    = X_ACC;
    Y_sel    = Y_DIN;
    Addr_sel = ADDR_PC;
    M        = ALU_Y;
    Rd       = 1'b0;
    Wr       = 1'b0;
    Retire   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        Addr_sel = ADDR_PC;
        Rd       = 1'b1;
        X_sel    = X_PC;
        M        = ALU_INC;
        w_pc_en  = Mem_Rdy;
        w_ir_en  = Mem_Rdy;
      end
      ST_EXEC: begin
        case (w_op)
          OP_LDA: begin
            Addr_sel = ADDR_IR;
            Rd       = 1'b1;
            Y_sel    = Y_DIN;
            M        = ALU_Y;
            w_acc_en = Mem_Rdy;
            Retire   = Mem_Rdy;
          end
          OP_STA: begin
            Addr_sel = ADDR_IR;
            Wr       = 1'b1;
            X_sel    = X_ACC;
            Retire   = Mem_Rdy;
          end
          OP_ADD, OP_SUB: begin
            Addr_sel = ADDR_IR;
            Rd       = 1'b1;
            X_sel    = X_ACC;
            Y_sel    = Y_DIN;
            M        = (w_op == OP_ADD) ? ALU_ADD : ALU_SUB;
            w_acc_en = Mem_Rdy;
            Retire   = Mem_Rdy;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            Y_sel  = Y_IR;
            M      = ALU_Y;
            Retire = 1'b1;
            if (w_op == OP_JMP) begin
              w_pc_en = 1'b1;
            end else if (w_op == OP_JGE) begin
              w_pc_en = ~N;
            end else begin
              w_pc_en = ~Z;
            end
          end
          OP_STP: begin
            Retire = 1'b1;
          end
          default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
            Retire = 1'b0;
`else
            Retire = 1'b1;
`endif
          end
        endcase
      end
      default: begin
        Retire = 1'b0;
      end
    endcase
  end

  // Register enables are suppressed for as long as Reset is held
  assign PC_En    = w_pc_en  & ~Reset;
  assign IR_En    = w_ir_en  & ~Reset;
  assign Acc_En   = w_acc_en & ~Reset;
  assign fetch    = (r_state == ST_FETCH);
  assign Halted   = (r_state == ST_HALT);
  assign Err_code = r_err;

endmodule
